// File: rtl/execute_stage.sv
// RV32I execute stage: forwarding, ALU, branch/jump resolve, EX/MEM register.
// Redirect is combinational; M outputs lag E inputs by 1 cycle; stallM holds, flushM bubbles.
module execute_stage #(
  parameter int DPW = 32,
  parameter int ADW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stallM,
  input  logic           flushM,
  input  logic           regwriteE,
  input  logic           resultsrcE,
  input  logic           memwriteE,
  input  logic           branchE,
  input  logic           jumpE,
  input  logic           jalrE,
  input  logic           alusrcE,
  input  logic [3:0]     alucontrolE,
  input  logic [2:0]     funct3E,
  input  logic [DPW-1:0] Rd1E,
  input  logic [DPW-1:0] Rd2E,
  input  logic [DPW-1:0] immE,
  input  logic [DPW-1:0] pcE,
  input  logic [ADW-1:0] RdE,
  input  logic [1:0]     forwardAE,
  input  logic [1:0]     forwardBE,
  input  logic [DPW-1:0] resultW,
  output logic           pcsrcE,
  output logic [DPW-1:0] pctargetE,
  output logic           regwriteM,
  output logic           resultsrcM,
  output logic           memwriteM,
  output logic [DPW-1:0] aluresultM,
  output logic [DPW-1:0] Rd2M,
  output logic [ADW-1:0] RdM
);

  logic [DPW-1:0] srcA, fwdB, srcB, alu_out, exresult, jalr_sum;
  logic [4:0]     shamt;
  logic           taken;

  always_comb begin
    srcA = Rd1E;
    case (forwardAE)
      2'b01:   srcA = resultW;
      2'b10:   srcA = aluresultM;
      default: srcA = Rd1E;
    endcase
  end

  always_comb begin
    fwdB = Rd2E;
    case (forwardBE)
      2'b01:   fwdB = resultW;
      2'b10:   fwdB = aluresultM;
      default: fwdB = Rd2E;
    endcase
  end

  assign srcB  = alusrcE ? immE : fwdB;
  assign shamt = srcB[4:0];

  always_comb begin
    alu_out = '0;
    case (alucontrolE)
      4'b0000: alu_out = srcA + srcB;
      4'b0001: alu_out = srcA - srcB;
      4'b0010: alu_out = srcA & srcB;
      4'b0011: alu_out = srcA | srcB;
      4'b0100: alu_out = srcA ^ srcB;
      4'b0101: alu_out = {{(DPW-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      4'b0110: alu_out = {{(DPW-1){1'b0}}, (srcA < srcB)};
      4'b0111: alu_out = srcA << shamt;
      4'b1000: alu_out = srcA >> shamt;
      4'b1001: alu_out = $unsigned($signed(srcA) >>> shamt);
      4'b1010: alu_out = srcB;
      default: alu_out = '0;
    endcase
  end

  // Branch compare always uses the register operand, never the immediate.
  always_comb begin
    taken = 1'b0;
    case (funct3E)
      3'b000:  taken = (srcA == fwdB);
      3'b001:  taken = (srcA != fwdB);
      3'b100:  taken = ($signed(srcA) < $signed(fwdB));
      3'b101:  taken = ($signed(srcA) >= $signed(fwdB));
      3'b110:  taken = (srcA < fwdB);
      3'b111:  taken = (srcA >= fwdB);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum  = srcA + immE;
  assign pcsrcE    = jumpE | (branchE & taken);
  assign pctargetE = jalrE ? {jalr_sum[DPW-1:1], 1'b0} : (pcE + immE);
  assign exresult  = jumpE ? (pcE + DPW'(4)) : alu_out;

  always_ff @(posedge clk) begin
    if (rst || flushM) begin
      regwriteM  <= 1'b0;
      resultsrcM <= 1'b0;
      memwriteM  <= 1'b0;
      aluresultM <= '0;
      Rd2M       <= '0;
      RdM        <= '0;
    end else if (!stallM) begin
      regwriteM  <= regwriteE;
      resultsrcM <= resultsrcE;
      memwriteM  <= memwriteE;
      aluresultM <= exresult;
      Rd2M       <= fwdB;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stallM, flushM;
  logic        regwriteE, resultsrcE, memwriteE, branchE, jumpE, jalrE, alusrcE;
  logic [3:0]  alucontrolE;
  logic [2:0]  funct3E;
  logic [31:0] Rd1E, Rd2E, immE, pcE, resultW;
  logic [4:0]  RdE;
  logic [1:0]  forwardAE, forwardBE;
  logic        pcsrcE;
  logic [31:0] pctargetE;
  logic        regwriteM, resultsrcM, memwriteM;
  logic [31:0] aluresultM, Rd2M;
  logic [4:0]  RdM;

  int checks = 0;
  int errors = 0;

  // model state of the EX/MEM register
  logic        m_rw, m_rs, m_mw;
  logic [31:0] m_alu, m_rd2;
  logic [4:0]  m_rd;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM),
    .regwriteE(regwriteE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
    .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE), .alusrcE(alusrcE),
    .alucontrolE(alucontrolE), .funct3E(funct3E),
    .Rd1E(Rd1E), .Rd2E(Rd2E), .immE(immE), .pcE(pcE), .RdE(RdE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
    .pcsrcE(pcsrcE), .pctargetE(pctargetE),
    .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
    .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                      input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return rd;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    logic [31:0] fill;
    s = b[4:0];
    fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + (~b + 32'd1);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << s;
      4'd8:  return a >> s;
      4'd9:  return (a >> s) | fill;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic taken_ref(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic [31:0] e_srcA, e_fwdB, e_res, e_tgt;
  logic        e_pcsrc;

  // settle combinational outputs and compare redirect against the model
  task automatic settle();
    #1;
    e_srcA  = fwd(forwardAE, Rd1E, resultW, m_alu);
    e_fwdB  = fwd(forwardBE, Rd2E, resultW, m_alu);
    e_res   = jumpE ? pcE + 32'd4 : alu_ref(alucontrolE, e_srcA, alusrcE ? immE : e_fwdB);
    e_pcsrc = jumpE | (branchE & taken_ref(funct3E, e_srcA, e_fwdB));
    e_tgt   = jalrE ? ((e_srcA + immE) & 32'hFFFF_FFFE) : pcE + immE;
    chk("pcsrcE", {31'd0, pcsrcE}, {31'd0, e_pcsrc});
    chk("pctargetE", pctargetE, e_tgt);
  endtask

  // clock once, advance the model register and compare all M outputs
  task automatic tick();
    @(posedge clk);
    if (rst || flushM) begin
      m_rw = 0; m_rs = 0; m_mw = 0; m_alu = 0; m_rd2 = 0; m_rd = 0;
    end else if (!stallM) begin
      m_rw = regwriteE; m_rs = resultsrcE; m_mw = memwriteE;
      m_alu = e_res; m_rd2 = e_fwdB; m_rd = RdE;
    end
    #1;
    chk("regwriteM", {31'd0, regwriteM}, {31'd0, m_rw});
    chk("resultsrcM", {31'd0, resultsrcM}, {31'd0, m_rs});
    chk("memwriteM", {31'd0, memwriteM}, {31'd0, m_mw});
    chk("aluresultM", aluresultM, m_alu);
    chk("Rd2M", Rd2M, m_rd2);
    chk("RdM", {27'd0, RdM}, {27'd0, m_rd});
  endtask

  task automatic clr();
    rst = 0; stallM = 0; flushM = 0;
    regwriteE = 0; resultsrcE = 0; memwriteE = 0; branchE = 0; jumpE = 0; jalrE = 0;
    alusrcE = 0; alucontrolE = 0; funct3E = 0;
    Rd1E = 0; Rd2E = 0; immE = 0; pcE = 0; RdE = 0; resultW = 0;
    forwardAE = 0; forwardBE = 0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_rw"}, {31'd0, regwriteM}, 32'd0);
    chk({tag, "_rs"}, {31'd0, resultsrcM}, 32'd0);
    chk({tag, "_mw"}, {31'd0, memwriteM}, 32'd0);
    chk({tag, "_alu"}, aluresultM, 32'd0);
    chk({tag, "_rd2"}, Rd2M, 32'd0);
    chk({tag, "_rd"}, {27'd0, RdM}, 32'd0);
  endtask

  initial begin
    m_rw = 0; m_rs = 0; m_mw = 0; m_alu = 0; m_rd2 = 0; m_rd = 0;
    clr();
    rst = 1; regwriteE = 1; Rd1E = 32'h1234; RdE = 5'd4;
    settle(); tick();
    all_zero("reset");
    clr();

    // ALU corner cases
    Rd1E = 32'hFFFF_FFFF; immE = 1; alusrcE = 1; regwriteE = 1; RdE = 5'd3;
    settle(); tick();
    chk("add_wrap", aluresultM, 32'h0);
    Rd1E = 32'h8000_0000; immE = 4; alucontrolE = 4'd9;
    settle(); tick();
    chk("sra", aluresultM, 32'hF800_0000);
    Rd1E = 32'd1; immE = 32'hFFFF_FFFF; alucontrolE = 4'd6;
    settle(); tick();
    chk("sltu", aluresultM, 32'd1);
    alucontrolE = 4'd5;
    settle(); tick();
    chk("slt", aluresultM, 32'd0);

    // forwarding from M and W
    Rd1E = 32'd5; immE = 0; alucontrolE = 4'd0;
    settle(); tick();
    forwardAE = 2'b10; forwardBE = 2'b01; resultW = 32'd7; alusrcE = 0;
    alucontrolE = 4'd1; memwriteE = 1; Rd1E = 32'h111; Rd2E = 32'h222;
    settle(); tick();
    chk("fwd_sub", aluresultM, 32'hFFFF_FFFE);
    chk("fwd_store", Rd2M, 32'd7);
    clr();

    // branches
    Rd1E = 32'hFFFF_FFFF; Rd2E = 32'd1; pcE = 32'h100; immE = 32'h20;
    branchE = 1; funct3E = 3'b100;
    settle();
    chk("blt_pcsrc", {31'd0, pcsrcE}, 32'd1);
    chk("blt_target", pctargetE, 32'h120);
    tick();
    funct3E = 3'b110;
    settle();
    chk("bltu_pcsrc", {31'd0, pcsrcE}, 32'd0);
    tick();
    clr();

    // JALR
    pcE = 32'h40; Rd1E = 32'h1001; immE = 32'd2; jumpE = 1; jalrE = 1; regwriteE = 1; RdE = 5'd1;
    settle();
    chk("jalr_target", pctargetE, 32'h1002);
    chk("jalr_pcsrc", {31'd0, pcsrcE}, 32'd1);
    tick();
    chk("jalr_link", aluresultM, 32'h44);
    chk("jalr_rw", {31'd0, regwriteM}, 32'd1);
    clr();

    // stall holds, flush beats stall
    Rd1E = 32'h1234; alusrcE = 1; regwriteE = 1; RdE = 5'd7;
    settle(); tick();
    stallM = 1; Rd1E = 32'h9999; RdE = 5'd9; memwriteE = 1;
    settle(); tick();
    chk("stall_alu", aluresultM, 32'h1234);
    chk("stall_rd", {27'd0, RdM}, 32'd7);
    flushM = 1;
    settle(); tick();
    all_zero("flush");
    clr();

    // reset mid-stream, then resume
    Rd1E = 32'h55; alusrcE = 1; regwriteE = 1; RdE = 5'd2;
    settle(); tick();
    rst = 1; Rd1E = 32'h66;
    settle(); tick();
    all_zero("midrst");
    rst = 0;
    settle(); tick();
    chk("resume_alu", aluresultM, 32'h66);
    chk("resume_rw", {31'd0, regwriteM}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 31) == 0);
      flushM      = ($urandom_range(0, 15) == 0);
      stallM      = ($urandom_range(0, 7) == 0);
      regwriteE   = 1'($urandom);
      resultsrcE  = 1'($urandom);
      memwriteE   = 1'($urandom);
      branchE     = 1'($urandom);
      jumpE       = ($urandom_range(0, 3) == 0);
      jalrE       = jumpE & 1'($urandom);
      alusrcE     = 1'($urandom);
      alucontrolE = 4'($urandom);
      funct3E     = 3'($urandom);
      Rd1E        = ($urandom_range(0, 3) == 0) ? Rd2E : $urandom;
      Rd2E        = $urandom;
      immE        = $urandom;
      pcE         = $urandom;
      RdE         = 5'($urandom);
      resultW     = $urandom;
      forwardAE   = 2'($urandom);
      forwardBE   = 2'($urandom);
      settle(); tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
